// File: rtl/mux_sel_ctrl.sv
// Break-before-make sequencer for the console mux selector bus.
// Guard sequencing is compiled in only with MUX_SEL_CTRL_GUARD_EN defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a command; rejects and no-ops complete in 1 cycle
// ST_BREAK  | target output masked, old selector still driven
// ST_SETTLE | target output masked, new selector driven
module mux_sel_ctrl #(
    parameter int INPUT_COUNT  = 4,
    parameter int OUTPUT_COUNT = 4,
    parameter int GUARD_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [3:0]                cmd_out,
    input  logic [3:0]                cmd_sel,
    output logic                      cmd_done,
    output logic                      cmd_err,
    output logic                      busy,
    output logic [4*OUTPUT_COUNT-1:0] selectors,
    output logic [OUTPUT_COUNT-1:0]   out_mask
);

    localparam logic [4:0] OUT_LIM = 5'(OUTPUT_COUNT);
    localparam logic [3:0] IN_LIM  = 4'(INPUT_COUNT);
    localparam logic [3:0] PARK    = 4'hF;

    logic [4*OUTPUT_COUNT-1:0] sel_q;
    logic [OUTPUT_COUNT-1:0]   park_mask;
    logic                      done_q, err_q;
    logic [3:0]                cur_sel;
    logic                      cmd_bad, cmd_noop, accept;

    always_comb begin
        cur_sel = PARK;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            if (cmd_out == 4'(i)) cur_sel = sel_q[4*i +: 4];
            park_mask[i] = &sel_q[4*i +: 4];
        end
    end

    assign cmd_bad  = ({1'b0, cmd_out} >= OUT_LIM) || ((cmd_sel >= IN_LIM) && (cmd_sel != PARK));
    assign cmd_noop = !cmd_bad && (cmd_sel == cur_sel);
    assign accept   = cmd_valid && cmd_ready;

    assign selectors = sel_q;
    assign cmd_done  = done_q;
    assign cmd_err   = err_q;

`ifdef MUX_SEL_CTRL_GUARD_EN
    localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_SETTLE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    tgt_q;
    logic [3:0]    nsel_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '1;
            cnt_q   <= '0;
            tgt_q   <= '0;
            nsel_q  <= PARK;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else if (cmd_noop) begin
                            done_q <= 1'b1;
                        end else begin
                            tgt_q   <= cmd_out;
                            nsel_q  <= cmd_sel;
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (cnt_q == '0) begin
                        for (int i = 0; i < OUTPUT_COUNT; i++) begin
                            if (tgt_q == 4'(i)) sel_q[4*i +: 4] <= nsel_q;
                        end
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    // Parked outputs stay masked after SETTLE because park_mask is always ORed in.
    always_comb begin
        out_mask = park_mask;
        if (state_q != ST_IDLE) begin
            for (int i = 0; i < OUTPUT_COUNT; i++) begin
                if (tgt_q == 4'(i)) out_mask[i] = 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q  <= '1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                if (cmd_bad) begin
                    err_q <= 1'b1;
                end else begin
                    done_q <= 1'b1;
                    for (int i = 0; i < OUTPUT_COUNT; i++) begin
                        if (cmd_out == 4'(i)) sel_q[4*i +: 4] <= cmd_sel;
                    end
                end
            end
        end
    end

    assign cmd_ready = 1'b1;
    assign busy      = 1'b0;
    assign out_mask  = park_mask;
`endif

endmodule
